// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with clock glitch filter, parity/stop/timeout checks,
// E0/F0 prefix decoding and per-key held-state tracking.
module ps2_key_tracker #(
   parameter int unsigned               SYNC_STAGES = 3,
   parameter int unsigned               FILTER_LEN  = 8,
   parameter int unsigned               TIMEOUT_CYC = 50000,
   parameter int unsigned               NUM_KEYS    = 4,
   parameter logic [8*NUM_KEYS-1:0]     KEY_CODES   = 32'h231C1B1D,
   parameter logic [NUM_KEYS-1:0]       KEY_EXT     = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   output logic [NUM_KEYS-1:0] key_down,
   output logic                evt_valid,
   output logic [7:0]          evt_code,
   output logic                evt_break,
   output logic                evt_ext,
   output logic                frame_err
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   sclk_q, sclk_d, sdat_q, sdat_d;
   logic                     clk_s, dat_s;
   logic                     filt_q, filt_d, fall_q, fall_d;
   logic [FW-1:0]            fcnt_q, fcnt_d;
   logic [TW-1:0]            to_q, to_d;
   logic [7:0]               shift_q, shift_d, byte_q, byte_d;
   logic [2:0]               bcnt_q, bcnt_d;
   logic                     par_q, par_d, stb_q, stb_d, err_q, err_d;
   logic                     ext_q, ext_d, brk_q, brk_d;
   logic [NUM_KEYS-1:0]      keys_q, keys_d;
   logic                     ev_q, ev_d, evbrk_q, evbrk_d, evext_q, evext_d;
   logic [7:0]               code_q, code_d;

   // Synchroniser and glitch filter; fall is registered so the timeout
   // counter can clear on the same cycle the FSM sees the edge.
   always_comb begin
      sclk_d = {sclk_q[SYNC_STAGES-2:0], ps2_clk};
      sdat_d = {sdat_q[SYNC_STAGES-2:0], ps2_data};
      clk_s  = sclk_q[SYNC_STAGES-1];
      dat_s  = sdat_q[SYNC_STAGES-1];
      filt_d = filt_q;
      fcnt_d = '0;
      if (clk_s != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
         else                               fcnt_d = fcnt_q + FW'(1);
      end
      fall_d = filt_q & ~filt_d;
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcnt_d  = bcnt_q;
      par_d   = par_q;
      byte_d  = byte_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;
      to_d    = (state_q == IDLE || fall_d) ? '0 : to_q + TW'(1);
      if (fall_q) begin
         unique case (state_q)
            IDLE: if (!dat_s) begin
               state_d = DATA;
               bcnt_d  = '0;
            end
            DATA: begin
               shift_d = {dat_s, shift_q[7:1]};
               bcnt_d  = bcnt_q + 3'd1;
               if (bcnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s;
               state_d = STOP;
            end
            STOP: begin
               byte_d  = shift_q;
               stb_d   = (^{shift_q, par_q}) & dat_s;
               err_d   = ~stb_d;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && to_d == TW'(TIMEOUT_CYC - 1)) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end
   end

   always_comb begin
      ext_d   = ext_q;
      brk_d   = brk_q;
      keys_d  = keys_q;
      ev_d    = 1'b0;
      code_d  = code_q;
      evbrk_d = evbrk_q;
      evext_d = evext_q;
      if (err_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end else if (stb_q) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
         unique case (byte_q)
            8'hE0: begin ext_d = 1'b1; brk_d = brk_q; end
            8'hF0: begin brk_d = 1'b1; ext_d = ext_q; end
            8'hFA, 8'hEE, 8'hFE: ;
            8'hAA, 8'h00, 8'hFF: keys_d = '0;
            default: begin
               ev_d    = 1'b1;
               code_d  = byte_q;
               evbrk_d = brk_q;
               evext_d = ext_q;
               for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                  if (byte_q == KEY_CODES[8*i +: 8] && ext_q == KEY_EXT[i])
                     keys_d[i] = ~brk_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_q  <= '1;
         sdat_q  <= '1;
         filt_q  <= 1'b1;
         fcnt_q  <= '0;
         fall_q  <= 1'b0;
         state_q <= IDLE;
         to_q    <= '0;
         shift_q <= '0;
         bcnt_q  <= '0;
         par_q   <= 1'b0;
         byte_q  <= '0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         keys_q  <= '0;
         ev_q    <= 1'b0;
         code_q  <= '0;
         evbrk_q <= 1'b0;
         evext_q <= 1'b0;
      end else begin
         sclk_q  <= sclk_d;
         sdat_q  <= sdat_d;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
         fall_q  <= fall_d;
         state_q <= state_d;
         to_q    <= to_d;
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
         par_q   <= par_d;
         byte_q  <= byte_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
         ext_q   <= ext_d;
         brk_q   <= brk_d;
         keys_q  <= keys_d;
         ev_q    <= ev_d;
         code_q  <= code_d;
         evbrk_q <= evbrk_d;
         evext_q <= evext_d;
      end
   end

   assign key_down  = keys_q;
   assign evt_valid = ev_q;
   assign evt_code  = code_q;
   assign evt_break = evbrk_q;
   assign evt_ext   = evext_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: two instances (plain and E0-only key 0) driven by
// one PS/2 bit stream, checked every cycle against a byte-level model.
module tb_ps2_key_tracker;

   localparam int SYNC = 3;
   localparam int FLT  = 4;
   localparam int TMO  = 2000;
   // Drive at cycle k -> synchronised after SYNC edges, filtered after FLT
   // more, fall pulse cycle is k+SYNC+FLT; byte_stb +1, event +2.
   localparam int FALL_LAT = SYNC + FLT;
   localparam int ERR_LAT  = FALL_LAT + 1;
   localparam int EVT_LAT  = FALL_LAT + 2;
   localparam logic [31:0]     KC   = 32'h231C1B1D;
   localparam logic [1:0][3:0] KEXT = {4'b0001, 4'b0000};

   logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [1:0][3:0] kd;
   logic [1:0][7:0] ec;
   logic [1:0]      ev, eb, ex, fe;

   always #5 clk = ~clk;

   ps2_key_tracker #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYC(TMO),
                     .NUM_KEYS(4), .KEY_CODES(KC), .KEY_EXT(KEXT[0])) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_down(kd[0]), .evt_valid(ev[0]), .evt_code(ec[0]),
      .evt_break(eb[0]), .evt_ext(ex[0]), .frame_err(fe[0]));

   ps2_key_tracker #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYC(TMO),
                     .NUM_KEYS(4), .KEY_CODES(KC), .KEY_EXT(KEXT[1])) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_down(kd[1]), .evt_valid(ev[1]), .evt_code(ec[1]),
      .evt_break(eb[1]), .evt_ext(ex[1]), .frame_err(fe[1]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   bit chk_en = 1'b0;

   // Byte-level model state and scheduled expectations
   bit              m_ext, m_brk;
   logic [1:0][3:0] m_keys;
   bit              p_evt, p_brk, p_ext;
   logic [7:0]      p_code;
   int              evt_at = -1, err_at = -1, keys_at = -1;
   logic [7:0]      x_code;
   bit              x_brk, x_ext;
   logic [1:0][3:0] x_keys;
   logic [1:0][3:0] cur_keys;
   logic [7:0]      cur_code;
   bit              cur_brk, cur_ext;
   int              evt_seen [2];
   int              err_seen [2];
   int              err_last [2];
   int              last_fall;

   task automatic check(input string name, input int j, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, j, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         if (cyc == keys_at) cur_keys = x_keys;
         if (cyc == evt_at) begin
            cur_code = x_code;
            cur_brk  = x_brk;
            cur_ext  = x_ext;
         end
         for (int j = 0; j < 2; j++) begin
            check("evt_valid", j, ev[j], cyc == evt_at);
            check("frame_err", j, fe[j], cyc == err_at);
            check("key_down", j, kd[j], cur_keys[j]);
            check("evt_code", j, ec[j], cur_code);
            check("evt_break", j, eb[j], cur_brk);
            check("evt_ext", j, ex[j], cur_ext);
            if (ev[j]) evt_seen[j]++;
            if (fe[j]) begin
               err_seen[j]++;
               err_last[j] = cyc;
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Decoder rules applied to one received byte (good) or a dropped one.
   task automatic model_byte(input logic [7:0] b, input bit good);
      p_evt = 1'b0;
      if (!good) begin
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hFA || b == 8'hEE || b == 8'hFE) begin
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
         m_ext = 1'b0; m_brk = 1'b0; m_keys = '0;
      end else begin
         p_evt = 1'b1; p_code = b; p_brk = m_brk; p_ext = m_ext;
         for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++)
               if (KC[8*i +: 8] == b && KEXT[j][i] == m_ext) m_keys[j][i] = ~m_brk;
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop,
                             input int nfalls, input bit glitch);
      logic [10:0] bits;
      bit good;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      good = !par_flip && stop;
      if (nfalls == 11) model_byte(b, good);
      for (int i = 0; i < nfalls; i++) begin
         ps2_data = bits[i];
         wait_clk(20);
         if (glitch) begin
            ps2_clk = 1'b0; wait_clk(2); ps2_clk = 1'b1; wait_clk(28);
         end else wait_clk(30);
         ps2_clk   = 1'b0;
         last_fall = cyc;
         if (i == 10) begin
            if (!good) err_at = cyc + ERR_LAT;
            if (p_evt && good) begin
               evt_at = cyc + EVT_LAT;
               x_code = p_code; x_brk = p_brk; x_ext = p_ext;
            end
            keys_at = cyc + EVT_LAT;
            x_keys  = m_keys;
         end
         wait_clk(50);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_clk(20);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11, 1'b0);
   endtask

   task automatic reset_model();
      m_ext = 1'b0; m_brk = 1'b0; m_keys = '0; cur_keys = '0;
      cur_code = '0; cur_brk = 1'b0; cur_ext = 1'b0;
      evt_at = -1; err_at = -1; keys_at = -1;
   endtask

   initial begin
      int e0;
      logic [7:0] rb;
      reset_model();
      for (int j = 0; j < 2; j++) begin
         evt_seen[j] = 0; err_seen[j] = 0; err_last[j] = -1;
      end
      wait_clk(5);
      rst_n = 1'b1;
      chk_en = 1'b1;
      wait_clk(2);
      check("rst_key_down", 0, kd[0], 4'b0000);
      check("rst_evt_code", 0, ec[0], 8'h00);

      // Make and break of W
      send(8'h1D);
      check("make_w_keys", 0, kd[0], 4'b0001);
      check("make_w_keys", 1, kd[1], 4'b0000);
      check("make_w_code", 0, ec[0], 8'h1D);
      check("make_w_cnt", 0, evt_seen[0], 1);
      send(8'hF0); send(8'h1D);
      check("brk_w_keys", 0, kd[0], 4'b0000);
      check("brk_w_flag", 0, eb[0], 1'b1);
      check("brk_w_cnt", 0, evt_seen[0], 2);

      // Two keys held, release only one, typematic repeat
      send(8'h1D); send(8'h1C);
      check("two_keys", 0, kd[0], 4'b0101);
      send(8'hF0); send(8'h1D);
      check("one_left", 0, kd[0], 4'b0100);
      e0 = evt_seen[0];
      repeat (3) send(8'h1C);
      check("repeat_cnt", 0, evt_seen[0] - e0, 3);
      check("repeat_keys", 0, kd[0], 4'b0100);
      send(8'hF0); send(8'h1C);

      // Extended-only key 0 on instance 1
      send(8'h1D);
      check("ext_plain", 1, kd[1], 4'b0000);
      send(8'hE0); send(8'h1D);
      check("ext_make", 1, kd[1], 4'b0001);
      check("ext_flag", 1, ex[1], 1'b1);
      send(8'hE0); send(8'hF0); send(8'h1D);
      check("ext_brk", 1, kd[1], 4'b0000);
      check("ext_brk_plain", 0, kd[0], 4'b0001);
      send(8'hF0); send(8'h1D);

      // Parity and stop errors, then recovery
      e0 = err_seen[0];
      send_frame(8'h1D, 1'b1, 1'b1, 11, 1'b0);
      send_frame(8'h1D, 1'b0, 1'b0, 11, 1'b0);
      check("bad_frames", 0, err_seen[0] - e0, 2);
      check("bad_keys", 0, kd[0], 4'b0000);
      send(8'h1B);
      check("after_bad", 0, kd[0][1], 1'b1);

      // Timeout after 4 data bits
      send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
      m_ext = 1'b0; m_brk = 1'b0;
      err_at = last_fall + FALL_LAT + TMO - 1;
      wait_clk(2500);
      check("timeout_at", 0, err_last[0], last_fall + FALL_LAT + TMO - 1);
      send(8'h23);
      check("after_tmo", 0, kd[0], 4'b1010);

      // Glitches on ps2_clk have no effect
      send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
      check("glitch_keys", 0, kd[0], 4'b1110);

      // BAT clears all held keys without an event
      e0 = evt_seen[0];
      send(8'hAA);
      check("bat_keys", 0, kd[0], 4'b0000);
      check("bat_noevt", 0, evt_seen[0] - e0, 0);

      // Random byte stream with occasional faults and glitches
      for (int n = 0; n < 25; n++) begin
         case ($urandom_range(0, 9))
            0: rb = 8'h1D; 1: rb = 8'h1C; 2: rb = 8'h1B; 3: rb = 8'h23;
            4: rb = 8'hE0; 5: rb = 8'hF0; 6: rb = 8'hAA; 7: rb = 8'hFA;
            8: rb = 8'h00;
            default: rb = 8'($urandom);
         endcase
         send_frame(rb, $urandom_range(0, 7) == 0, $urandom_range(0, 15) != 0, 11,
                    $urandom_range(0, 3) == 0);
      end

      // Reset in the middle of a frame aborts without an error
      send_frame(8'h1D, 1'b0, 1'b1, 5, 1'b0);
      rst_n = 1'b0;
      reset_model();
      wait_clk(3);
      rst_n = 1'b1;
      e0 = err_seen[0];
      wait_clk(2100);
      check("rst_abort", 0, err_seen[0] - e0, 0);
      send(8'h1B);
      check("after_rst", 0, kd[0], 4'b0010);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
